// File: rtl/common_pkg.sv
// Shared types for the systolic matrix-multiply core and its processing elements.
package common_pkg;
    localparam int ACC_W_MAX  = 64;
    localparam int OPND_W_MAX = 32;

    typedef logic signed [ACC_W_MAX-1:0]  acc_t;
    typedef logic signed [OPND_W_MAX-1:0] operand_t;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FLUSH, ST_DRAIN} state_t;
endpackage

// File: rtl/mac_pe.sv
// Systolic MAC cell: registered A/B pass-through plus signed accumulator with clear.
// Define MM_SATURATE_EN to clamp the accumulator instead of wrapping.
module mac_pe
    import common_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);
    logic [DATA_W-1:0] a_q, b_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    operand_t          a_x, b_x;
    acc_t              a_w, b_w, acc_x, sum;

`ifdef MM_SATURATE_EN
    localparam acc_t SAT_HI = (acc_t'(1) <<< (ACC_W-1)) - acc_t'(1);
    localparam acc_t SAT_LO = -(acc_t'(1) <<< (ACC_W-1));
`else
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum[ACC_W_MAX-1:ACC_W];
`endif

    // Full-width sum never overflows, so clamping or wrapping is a simple slice/compare.
    always_comb begin
        a_x   = {{(OPND_W_MAX-DATA_W){a_i[DATA_W-1]}}, a_i};
        b_x   = {{(OPND_W_MAX-DATA_W){b_i[DATA_W-1]}}, b_i};
        a_w   = {{(ACC_W_MAX-OPND_W_MAX){a_x[OPND_W_MAX-1]}}, a_x};
        b_w   = {{(ACC_W_MAX-OPND_W_MAX){b_x[OPND_W_MAX-1]}}, b_x};
        acc_x = {{(ACC_W_MAX-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        sum   = acc_x + a_w * b_w;
`ifdef MM_SATURATE_EN
        if (sum > SAT_HI)      acc_d = SAT_HI[ACC_W-1:0];
        else if (sum < SAT_LO) acc_d = SAT_LO[ACC_W-1:0];
        else                   acc_d = sum[ACC_W-1:0];
`else
        acc_d = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (en_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
endmodule

// File: rtl/mm_systolic_core.sv
// Output-stationary ROWS x COLS systolic matrix-multiply core with skewed operand entry
// and row-by-row result drain. Define MM_SATURATE_EN for saturating accumulation.
module mm_systolic_core
    import common_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [$clog2(K_MAX+1)-1:0] k_len_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ROWS*DATA_W-1:0]     a_i,
    input  logic [COLS*DATA_W-1:0]     b_i,
    output logic                       c_valid_o,
    input  logic                       c_ready_i,
    output logic [COLS*ACC_W-1:0]      c_o,
    output logic [$clog2(ROWS)-1:0]    c_row_o,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int KW = $clog2(K_MAX+1);
    localparam int RW = $clog2(ROWS);
    localparam int FW = $clog2(ROWS+COLS);
    localparam logic [FW-1:0] FLUSH_CYC = FW'(ROWS+COLS-1);

    state_t         state_q, state_d;
    logic [KW-1:0]  beats_q, beats_d;
    logic [FW-1:0]  flush_q, flush_d;
    logic [RW-1:0]  row_q, row_d;
    logic           accept, adv, clr;

    logic [DATA_W-1:0] a_bus [ROWS][COLS+1];
    logic [DATA_W-1:0] b_bus [ROWS+1][COLS];
    logic [ACC_W-1:0]  acc_w [ROWS][COLS];
    logic [ROWS-1:0]   unused_a_tail;
    logic [COLS-1:0]   unused_b_tail;

    assign accept = (state_q == ST_STREAM) && in_valid_i;
    assign adv    = (state_q == ST_STREAM) || (state_q == ST_FLUSH);

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        flush_d = flush_q;
        row_d   = row_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: if (start_i) begin
                clr     = 1'b1;
                beats_d = k_len_i;
                row_d   = '0;
                state_d = (k_len_i == '0) ? ST_DRAIN : ST_STREAM;
            end
            ST_STREAM: if (accept) begin
                beats_d = beats_q - 1'b1;
                if (beats_q == KW'(1)) begin
                    flush_d = FLUSH_CYC;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_d = flush_q - 1'b1;
                if (flush_q == FW'(1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (c_ready_i) begin
                if (row_q == RW'(ROWS-1)) begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            beats_q <= '0;
            flush_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            flush_q <= flush_d;
            row_q   <= row_d;
        end
    end

    // Row r / column c enter through r / c delay stages so operands of beat k meet at PE(r,c).
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        logic [DATA_W-1:0] a_in;
        assign a_in = accept ? a_i[r*DATA_W +: DATA_W] : '0;
        if (r == 0) begin : g_d0
            assign a_bus[0][0] = a_in;
        end else begin : g_dn
            logic [DATA_W-1:0] sk_q [r];
            always_ff @(posedge clk_i) begin
                if (rst_i || clr) begin
                    for (int i = 0; i < r; i++) sk_q[i] <= '0;
                end else if (adv) begin
                    sk_q[0] <= a_in;
                    for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
                end
            end
            assign a_bus[r][0] = sk_q[r-1];
        end
        assign unused_a_tail[r] = ^a_bus[r][COLS];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        logic [DATA_W-1:0] b_in;
        assign b_in = accept ? b_i[c*DATA_W +: DATA_W] : '0;
        if (c == 0) begin : g_d0
            assign b_bus[0][0] = b_in;
        end else begin : g_dn
            logic [DATA_W-1:0] sk_q [c];
            always_ff @(posedge clk_i) begin
                if (rst_i || clr) begin
                    for (int i = 0; i < c; i++) sk_q[i] <= '0;
                end else if (adv) begin
                    sk_q[0] <= b_in;
                    for (int i = 1; i < c; i++) sk_q[i] <= sk_q[i-1];
                end
            end
            assign b_bus[0][c] = sk_q[c-1];
        end
        assign unused_b_tail[c] = ^b_bus[ROWS][c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (adv),
                .clr_i (clr),
                .a_i   (a_bus[r][c]),
                .b_i   (b_bus[r][c]),
                .a_o   (a_bus[r][c+1]),
                .b_o   (b_bus[r+1][c]),
                .acc_o (acc_w[r][c])
            );
        end
    end

    // Outputs are gated by reset so they read zero even before the first reset edge lands.
    assign in_ready_o = !rst_i && (state_q == ST_STREAM);
    assign busy_o     = !rst_i && (state_q != ST_IDLE);
    assign c_valid_o  = !rst_i && (state_q == ST_DRAIN);
    assign done_o     = c_valid_o && c_ready_i && (row_q == RW'(ROWS-1));
    assign c_row_o    = c_valid_o ? row_q : '0;

    always_comb begin
        c_o = '0;
        if (c_valid_o) begin
            for (int c = 0; c < COLS; c++) c_o[c*ACC_W +: ACC_W] = acc_w[row_q][c];
        end
    end
endmodule

// File: tb/tb_mm_systolic_core.sv
// Directed/randomized bench for mm_systolic_core (4x4, 8-bit operands, 16-bit accumulators).
module tb_mm_systolic_core;
    localparam int ROWS = 4, COLS = 4, DATA_W = 8, ACC_W = 16, K_MAX = 255;
    localparam int KW = $clog2(K_MAX+1);
    localparam int RW = $clog2(ROWS);

    logic                   clk = 1'b0;
    logic                   rst_i, start_i, in_valid_i, c_ready_i;
    logic [KW-1:0]          k_len_i;
    logic [ROWS*DATA_W-1:0] a_i;
    logic [COLS*DATA_W-1:0] b_i;
    logic                   in_ready_o, c_valid_o, busy_o, done_o;
    logic [COLS*ACC_W-1:0]  c_o;
    logic [RW-1:0]          c_row_o;

    always #5 clk = ~clk;

    mm_systolic_core #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_MAX(K_MAX)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .a_i(a_i), .b_i(b_i),
        .c_valid_o(c_valid_o), .c_ready_i(c_ready_i), .c_o(c_o), .c_row_o(c_row_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    int     checks = 0;
    int     errors = 0;
    int     a_m [K_MAX][ROWS];
    int     b_m [K_MAX][COLS];
    longint exp_c [ROWS][COLS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Reference: C = A * B accumulated beat by beat in the signed ACC_W range.
    function automatic longint fold(input longint v);
        longint lim, m;
        lim = longint'(1) << (ACC_W-1);
`ifdef MM_SATURATE_EN
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
`else
        m = v % (2*lim);
        if (m < 0) m += 2*lim;
        if (m >= lim) m -= 2*lim;
        return m;
`endif
    endfunction

    task automatic compute_expected(input int k);
        longint acc;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                acc = 0;
                for (int i = 0; i < k; i++) acc = fold(acc + longint'(a_m[i][r]) * longint'(b_m[i][c]));
                exp_c[r][c] = acc;
            end
    endtask

    task automatic fill_random(input int k);
        for (int i = 0; i < k; i++) begin
            for (int r = 0; r < ROWS; r++) a_m[i][r] = int'($urandom_range(0, 255)) - 128;
            for (int c = 0; c < COLS; c++) b_m[i][c] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    function automatic longint elem(input int c);
        logic signed [ACC_W-1:0] e;
        e = c_o[c*ACC_W +: ACC_W];
        return longint'(e);
    endfunction

    // Entered and left #1 after a rising edge; issues start and streams k beats.
    task automatic feed_beats(input int k, input bit gaps, input bit poke_start);
        int idx, cyc;
        start_i = 1'b1;
        k_len_i = KW'(k);
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        idx = 0;
        cyc = 0;
        while (idx < k && cyc < 4*k + 8) begin
            in_valid_i = !gaps || (cyc % 2 == 0);
            start_i    = poke_start;
            k_len_i    = KW'($urandom_range(0, K_MAX));
            for (int r = 0; r < ROWS; r++)
                a_i[r*DATA_W +: DATA_W] = in_valid_i ? DATA_W'(a_m[idx][r]) : DATA_W'($urandom);
            for (int c = 0; c < COLS; c++)
                b_i[c*DATA_W +: DATA_W] = in_valid_i ? DATA_W'(b_m[idx][c]) : DATA_W'($urandom);
            #1;
            if (cyc < 3 || idx == k-1) chk("in_ready_stream", in_ready_o, 1);
            @(posedge clk); #1;
            if (in_valid_i) idx++;
            cyc++;
        end
        chk("beats_accepted", idx, k);
        in_valid_i = 1'b0;
        start_i    = 1'b0;
        a_i        = '0;
        b_i        = '0;
    endtask

    task automatic run_tile(input int k, input bit gaps, input bit poke_start,
                            input int stall_row, input int stall_len);
        int wait_n;
        compute_expected(k);
        feed_beats(k, gaps, poke_start);
        wait_n = 0;
        while (!c_valid_o && wait_n < 40) begin
            if (wait_n == 0) chk("in_ready_flush", in_ready_o, 0);
            @(posedge clk); #1;
            wait_n++;
        end
        chk("flush_cycles", wait_n, (k == 0) ? 0 : ROWS + COLS - 1);
        for (int r = 0; r < ROWS; r++) begin
            c_ready_i = (r != stall_row);
            #1;
            chk("c_valid_drain", c_valid_o, 1);
            chk("c_row", c_row_o, r);
            for (int c = 0; c < COLS; c++) chk($sformatf("c_r%0d_c%0d", r, c), elem(c), exp_c[r][c]);
            if (r == stall_row) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk); #1;
                    chk("stall_row", c_row_o, r);
                    chk("stall_done", done_o, 0);
                    for (int c = 0; c < COLS; c++) chk("stall_c", elem(c), exp_c[r][c]);
                end
                c_ready_i = 1'b1;
                #1;
            end
            chk("done_pulse", done_o, (r == ROWS-1) ? 1 : 0);
            @(posedge clk); #1;
        end
        c_ready_i = 1'b0;
        chk("busy_end", busy_o, 0);
        chk("c_valid_idle", c_valid_o, 0);
        chk("done_idle", done_o, 0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; c_ready_i = 1'b0;
        k_len_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_c_valid", c_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_c_o", c_o, 0);
        chk("rst_c_row", c_row_o, 0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Identity A times B = 1..16.
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < ROWS; r++) a_m[i][r] = (r == i) ? 1 : 0;
            for (int c = 0; c < COLS; c++) b_m[i][c] = 4*i + c + 1;
        end
        run_tile(4, 1'b0, 1'b0, -1, 0);

        // Same random operands with and without input gaps; start_i poked mid-stream.
        fill_random(4);
        run_tile(4, 1'b0, 1'b0, -1, 0);
        run_tile(4, 1'b1, 1'b1, -1, 0);

        // Back-pressure on row 1.
        fill_random(6);
        run_tile(6, 1'b0, 1'b0, 1, 5);

        // Empty inner dimension.
        run_tile(0, 1'b0, 1'b0, -1, 0);

        // Abort during FLUSH, then a clean tile.
        fill_random(4);
        feed_beats(4, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_in_ready", in_ready_o, 0);
        chk("abort_c_valid", c_valid_o, 0);
        chk("abort_c_o", c_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("abort_busy_after", busy_o, 0);
        fill_random(5);
        run_tile(5, 1'b0, 1'b0, -1, 0);

        // Random lengths with gaps.
        for (int t = 0; t < 3; t++) begin
            int k;
            k = int'($urandom_range(1, 20));
            fill_random(k);
            run_tile(k, t[0], 1'b0, int'($urandom_range(0, ROWS-1)), 2);
        end

        // Full-length overflow case: A = B = -128, k = 255.
        for (int i = 0; i < 255; i++) begin
            for (int r = 0; r < ROWS; r++) a_m[i][r] = -128;
            for (int c = 0; c < COLS; c++) b_m[i][c] = -128;
        end
        run_tile(255, 1'b0, 1'b0, -1, 0);
`ifdef MM_SATURATE_EN
        chk("sat_const", exp_c[0][0], 32767);
`else
        chk("wrap_const", exp_c[0][0], -16384);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
